picomem_sram_param: RTL

Parametrised single-port on-chip SRAM slave for the PicoRV32 native memory bus. It is the generic successor of the fixed 8 KB/32 KB boot and data RAM blocks, and sits behind the interconnect address decoder. It adds arbitrary (non-power-of-two) depth, programmable wait states, out-of-range error reporting and an optional output register stage. Storage is four 8-bit byte lanes with per-lane write enables.

---
 rtl/picomem_sram_param_if.sv | 20 ++
 rtl/picomem_sram_param.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/picomem_sram_param_if.sv
// PicoRV32 native memory bus bundle for picomem_sram_param.
// master drives valid/addr/wdata/wstrb; slave returns ready/rdata.
interface picomem_sram_param_if;
    logic        mem_s_valid;
    logic [31:0] mem_s_addr;
    logic [31:0] mem_s_wdata;
    logic [3:0]  mem_s_wstrb;
    logic        mem_s_ready;
    logic [31:0] mem_s_rdata;

    modport master (
        output mem_s_valid, mem_s_addr, mem_s_wdata, mem_s_wstrb,
        input  mem_s_ready, mem_s_rdata
    );

    modport slave (
        input  mem_s_valid, mem_s_addr, mem_s_wdata, mem_s_wstrb,
        output mem_s_ready, mem_s_rdata
    );
endinterface

// File: rtl/picomem_sram_param.sv
// Parametrised single-port byte-lane SRAM slave for the PicoRV32 bus with
// wait states, out-of-range error reporting and optional output register.
// Ports: clk, reset (sync, active-high), bus (slave modport: valid/addr/
// wdata/wstrb in, ready/rdata out), err_pulse, err_sticky, err_clr.
// Macro PICOMEM_SRAM_OUTREG_EN adds the OREG state (+1 cycle latency).
module picomem_sram_param #(
    parameter int    DEPTH_WORDS = 2048,
    parameter int    WAIT_CYCLES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic                 clk,
    input  logic                 reset,
    picomem_sram_param_if.slave  bus,
    output logic                 err_pulse,
    output logic                 err_sticky,
    input  logic                 err_clr
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYCLES);
    localparam bit          LIVE    = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
`ifdef PICOMEM_SRAM_OUTREG_EN
        OREG,
`endif
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rd_q;
    logic        ready_q;
`ifdef PICOMEM_SRAM_OUTREG_EN
    logic [31:0] out_q;
    logic        oor_q;
`endif

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_wstrb;
    logic [AW-1:0] acc_idx;
    logic          acc_oor;
    logic          acc;
    logic          mem_we;
    logic          unused_addr;

    // With no wait states the array sees the live bus on the accept edge;
    // otherwise the request latched at accept time is replayed.
    always_comb begin
        acc_addr  = LIVE ? bus.mem_s_addr  : addr_q;
        acc_wdata = LIVE ? bus.mem_s_wdata : wdata_q;
        acc_wstrb = LIVE ? bus.mem_s_wstrb : wstrb_q;
        acc_idx   = acc_addr[AW+1:2];
        acc_oor   = {1'b0, acc_idx} >= DEPTH_L;
        acc       = (state == IDLE && bus.mem_s_valid && LIVE) ||
                    (state == WAIT && cnt == 4'd1);
        mem_we    = acc && !acc_oor && !reset;
    end

    assign unused_addr = ^{acc_addr[31:AW+2], acc_addr[1:0]};

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wstrb[i])
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
            rd_q       <= 32'h0;
            ready_q    <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
`ifdef PICOMEM_SRAM_OUTREG_EN
            out_q      <= 32'h0;
            oor_q      <= 1'b0;
`endif
        end else begin
            ready_q   <= 1'b0;
            err_pulse <= 1'b0;

            if (state == RESP && err_pulse)
                err_sticky <= 1'b1;
            else if (err_clr)
                err_sticky <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (bus.mem_s_valid) begin
                        addr_q  <= bus.mem_s_addr;
                        wdata_q <= bus.mem_s_wdata;
                        wstrb_q <= bus.mem_s_wstrb;
                        cnt     <= WAIT_L;
                        state   <= WAIT;
                    end
                end
                WAIT: cnt <= cnt - 4'd1;
`ifdef PICOMEM_SRAM_OUTREG_EN
                OREG: begin
                    out_q     <= rd_q;
                    ready_q   <= 1'b1;
                    err_pulse <= oor_q;
                    state     <= RESP;
                end
`endif
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase

            // Access edge overrides the IDLE/WAIT transitions above.
            if (acc) begin
                rd_q <= acc_oor ? 32'h0 : mem[acc_idx];
`ifdef PICOMEM_SRAM_OUTREG_EN
                oor_q     <= acc_oor;
                state     <= OREG;
`else
                ready_q   <= 1'b1;
                err_pulse <= acc_oor;
                state     <= RESP;
`endif
            end
        end
    end

    assign bus.mem_s_ready = ready_q;
`ifdef PICOMEM_SRAM_OUTREG_EN
    assign bus.mem_s_rdata = out_q;
`else
    assign bus.mem_s_rdata = rd_q;
`endif
endmodule
